// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, FSM encoding and the
// initial-carry rule used when an operation is accepted.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_NOT  = 4'b1010;
  localparam logic [3:0] OP_PASS = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Subtraction is done as A + ~B + 1, so the carry chain starts at 1.
  function automatic logic init_carry(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit combinational ALU slice: full adder, subtractor and logic cells
// selected by the op code. Carry out is 0 for logical and unknown ops.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] op,
  output logic       r,
  output logic       cout
);

  logic nb;
  logic fa_s, fa_c;
  logic sb_s, sb_c;

  assign nb   = ~b;
  assign fa_s = a ^ b ^ cin;
  assign fa_c = (a & b) | (cin & (a ^ b));
  assign sb_s = a ^ nb ^ cin;
  assign sb_c = (a & nb) | (cin & (a ^ nb));

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  begin r = fa_s; cout = fa_c; end
      OP_SUB,
      OP_SLT:  begin r = sb_s; cout = sb_c; end
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      default: begin r = 1'b0; cout = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_bit_serial.sv
// Bit-serial ALU: one bit per clock, LSB first, through a single slice.
// Results and flags are published only on the edge that enters DONE.
module alu_bit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic             prime_q, prime_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             slice_r, slice_cout;
  logic [WIDTH-1:0] sh_next;
  logic             ovf_bit;
  logic             last_bit;
  logic             accept;

  alu_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  // Handshake: a request is taken on a rising edge where start=1 and
  // ready=1; ready is high in IDLE and DONE, start elsewhere is dropped.
  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = start && ready;
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

  assign sh_next  = {slice_r, sh_q};
  assign ovf_bit  = carry_q ^ slice_cout;
  assign last_bit = !prime_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    prime_d  = prime_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    if (accept) begin
      state_d = ST_RUN;
      // Requests from IDLE take one settle cycle; from DONE they start at once.
      prime_d = (state_q == ST_IDLE);
      cnt_d   = '0;
      op_d    = op;
      a_d     = a;
      b_d     = b;
      sh_d    = '0;
      carry_d = init_carry(op);
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      if (prime_q) begin
        prime_d = 1'b0;
      end else begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sh_d    = sh_next[WIDTH-1:1];
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          case (op_q)
            OP_ADD, OP_SUB: begin
              result_d = sh_next;
              cout_d   = slice_cout;
              ovf_d    = ovf_bit;
            end
            OP_SLT: begin
              result_d = WIDTH'(slice_r ^ ovf_bit);
              cout_d   = slice_cout;
              ovf_d    = 1'b0;
            end
            OP_AND, OP_OR, OP_XNOR, OP_NOT, OP_PASS: begin
              result_d = sh_next;
              cout_d   = 1'b0;
              ovf_d    = 1'b0;
            end
            default: begin
              result_d = '0;
              cout_d   = 1'b0;
              ovf_d    = 1'b0;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prime_q  <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prime_q  <= prime_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_bit_serial.sv
// Scoreboard bench for alu_bit_serial: driver pushes reference results,
// a negedge monitor pops them whenever done is seen.
module tb_alu_bit_serial;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         ready, done, zero, carry_out, overflow;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int t_done   = 0;
  int lat      = 0;
  int d_first  = 0;

  logic [W+2:0] exp_q[$];

  alu_bit_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: {result, zero, carry_out, overflow} from plain arithmetic.
  function automatic logic [W+2:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0110: begin
        s = {1'b0, x} - {1'b0, y};
        r = s[W-1:0]; c = (x >= y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0111: begin
        r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
        c = (x >= y);
      end
      4'b1001: r = ~(x ^ y);
      4'b1010: r = ~x;
      4'b1011: r = x;
      default: r = '0;
    endcase
    return {r, (r == '0), c, v};
  endfunction

  // driver tasks
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) begin
      n_checks++;
      $display("FAIL issue_timeout: ready stayed 0 for %0d cycles", n);
    end
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    t_start = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk); n++;
    while (!done && n < 200) begin @(negedge clk); n++; end
    if (!done) begin
      n_checks++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
    t_done = cyc;
    lat = cyc - t_start + 1;
  endtask

  task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y);
    wait_done();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: result %h with empty queue", result);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(result), 64'(e[W+2:3]));
        check("zero", 64'(zero), 64'(e[2]));
        check("carry_out", 64'(carry_out), 64'(e[1]));
        check("overflow", 64'(overflow), 64'(e[0]));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(ready), 64'(1));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_zero"}, 64'(zero), 64'(1));
    check({tag, "_carry"}, 64'(carry_out), 64'(0));
    check({tag, "_ovf"}, 64'(overflow), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  logic [3:0] ops [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1001,
                           4'b1010, 4'b1011, 4'b0011, 4'b1111, 4'b0100};

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    // ADD overflow with latency and single-cycle done pulse
    run(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    check("latency_edges", 64'(lat), 64'(W + 2));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("ready_idle", 64'(ready), 64'(1));

    // back-to-back: second request accepted in DONE
    run(4'b0110, 32'd5, 32'd5);
    d_first = t_done;
    run(4'b0110, 32'd0, 32'd1);
    check("b2b_spacing", 64'(t_done - d_first), 64'(W + 1));

    run(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    run(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF);
    run(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
    run(4'b0000, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    run(4'b0001, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    run(4'b1001, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    run(4'b1010, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    run(4'b1011, 32'hF0F0_A5A5, 32'h0FF0_FFFF);

    // start during RUN is ignored; previous result is held meanwhile
    issue(4'b0010, 32'h1234_5678, 32'h1111_1111);
    repeat (10) @(negedge clk);
    check("result_held", 64'(result), 64'(32'hF0F0_A5A5));
    check("busy_not_ready", 64'(ready), 64'(0));
    start = 1'b1; op = 4'b0110; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset in the middle of RUN
    repeat (2) @(negedge clk);
    issue(4'b0010, 32'h0000_0001, 32'h0000_0002);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_vals("mid_run_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(4'b0010, 32'd3, 32'd4);
    check("fresh_add", 64'(result), 64'(7));

    // randomized operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = $urandom();
      y = $urandom();
      if ($urandom_range(0, 4) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) y = x;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(ops[$urandom_range(0, 10)], x, y);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_bit_serial.md
# alu_bit_serial

Multi-cycle bit-serial ALU for the datapath. It processes one bit per clock, LSB first, through a single combinational bit slice (`alu_bit_slice`) built from the team's existing full-adder, subtractor and logic-gate cells. A carry flip-flop and shift registers sequence the operation over `WIDTH` cycles. It sits between the ALU-control/operand stage and the write-back path, and trades latency for one slice of area.

## Interface
Parameters:
- `WIDTH`, default 32. Operand and result width; must be at least 2.

Ports:
- `clk`  in  1  Single clock. All state changes on its rising edge.
- `rst`  in  1  Reset, asynchronous and active-high.
- `start`  in  1  Request. Accepted only while `ready`=1.
- `op`  in  4  Operation code, sampled with `start`.
- `a`  in  WIDTH  Operand A, sampled with `start`.
- `b`  in  WIDTH  Operand B, sampled with `start`.
- `ready`  out  1  High in IDLE and DONE.
- `done`  out  1  One-cycle pulse when `result` and the flags become valid.
- `result`  out  WIDTH  Result, held until the next accepted `start`.
- `zero`  out  1  High when `result`==0, held with `result`.
- `carry_out`  out  1  Final carry for ADD/SUB/SLT; 0 for logical ops.
- `overflow`  out  1  Signed overflow for ADD/SUB; 0 otherwise.

## Operation
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A-B); 0111 SLT (signed A<B).
  - 1001 XNOR; 1010 NOT A; 1011 PASS A.
  - Any other code: `result`=0, all flags 0, same latency.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start` latches `a`, `b`, `op` into shift registers, loads the carry flip-flop, clears the bit counter, and moves to RUN.
  - RUN: each cycle feeds bit 0 of the A/B shift registers, plus the carry flip-flop, into the slice. The slice output shifts into the MSB of the result register and the carry flip-flop updates. The counter increments; after bit WIDTH-1 the FSM moves to DONE.
  - DONE: asserts `done`, publishes the flags, and returns to IDLE. If `start` is high here, it is accepted instead, going straight to RUN.
- Initial carry: 1 for SUB and SLT (A + ~B + 1); 0 for all other ops.
- Flags:
  - `overflow` = carry into MSB XOR carry out of MSB, for ADD/SUB.
  - `carry_out` = final carry for ADD/SUB/SLT. For SUB, 1 means no borrow.
- SLT: after the serial subtraction, `result` = {WIDTH-1 zeros, diff_msb XOR overflow}. `carry_out` follows the subtraction; `overflow` is 0.
- `zero` is evaluated on the final published `result`.
- `start` while RUN is ignored; no queuing, no error.
- Arithmetic is modulo 2^WIDTH; operands are two's complement for SLT and overflow.

## Timing
- Reset values: state=IDLE, `ready`=1, `done`=0, `result`=0, `zero`=1, `carry_out`=0, `overflow`=0, counter=0.
- Latency: `start` sampled at edge T; `done` is high during the cycle after edge T+WIDTH+1. That is WIDTH+2 edges from request to pulse, e.g. 34 for WIDTH=32.
- Throughput: one operation per WIDTH+1 cycles with back-to-back `start` in DONE.
- `result` and the flags change only on the edge entering DONE. They are stable from the `done` cycle until the next completion.
- Reset asserted mid-RUN: immediate return to reset values. The partial result is discarded and no `done` is issued.
- Counter width is $clog2(WIDTH). The counter never wraps within one operation.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XNOR, OP_NOT, OP_PASS);
  - FSM state encoding.
- Sub-module `alu_bit_slice`: purely combinational.
  - Inputs `a`, `b`, `cin`, `op`; outputs `r`, `cout`.
  - Selects among FullAdder, Subtractor, AND, OR, XNOR, NOT and pass-through cell outputs.
  - `cout`=0 for logical ops.
- The top level holds the FSM, the shift registers, the carry flip-flop and the flag logic.

## Test plan
All scenarios use WIDTH=32.
- ADD a=0x7FFFFFFF, b=1 -> `result`=0x80000000, `overflow`=1, `carry_out`=0, `zero`=0. `done` appears exactly 34 edges after the start edge.
- SUB a=5, b=5 -> `result`=0, `zero`=1, `carry_out`=1, `overflow`=0. Then SUB a=0, b=1 -> 0xFFFFFFFF, `carry_out`=0.
- SLT a=0xFFFFFFFF (-1), b=1 -> `result`=1. SLT a=0x80000000, b=0x7FFFFFFF -> `result`=1 (overflow case). SLT a=1, b=-1 -> `result`=0.
- Logical ops with a=0xF0F0A5A5, b=0x0FF0FFFF:
  - AND -> 0x00F0A5A5; OR -> 0xFFF0FFFF; XNOR -> 0x00FFA5A5;
  - NOT -> 0x0F0F5A5A; PASS -> 0xF0F0A5A5;
  - `carry_out`=0 and `overflow`=0 for each.
- `start` pulsed with new operands at RUN cycle 10 -> ignored; the original operation's result is returned. A back-to-back `start` in DONE -> second `done` exactly 33 cycles after the first.
- Reset asserted at RUN cycle 17 -> next cycle shows reset values, `ready`=1, and no `done`. A fresh ADD 3+4 then returns 7.
